// File: rtl/rs_issue_scheduler_if.sv
// Bus between the reservation station/ALU side and the issue scheduler.
// master = scheduler, slave = RS/ALU environment.
interface rs_issue_scheduler_if #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4,
  parameter int ROB_W   = 4
);
  logic [RS_SIZE-1:0]       ent_ready;
  logic [RS_SIZE*6-1:0]     ent_op;
  logic [RS_SIZE*32-1:0]    ent_vj;
  logic [RS_SIZE*32-1:0]    ent_vk;
  logic [RS_SIZE*ROB_W-1:0] ent_rob;
  logic                     free_valid;
  logic [IDX_W-1:0]         free_idx;
  logic                     issue_valid;
  logic [5:0]               issue_op;
  logic [31:0]              issue_vj;
  logic [31:0]              issue_vk;
  logic [ROB_W-1:0]         issue_rob;
  logic                     alu_ready;

  modport master (
    input  ent_ready, ent_op, ent_vj, ent_vk, ent_rob, alu_ready,
    output free_valid, free_idx, issue_valid, issue_op, issue_vj, issue_vk, issue_rob
  );
  modport slave (
    output ent_ready, ent_op, ent_vj, ent_vk, ent_rob, alu_ready,
    input  free_valid, free_idx, issue_valid, issue_op, issue_vj, issue_vk, issue_rob
  );
endinterface

// File: rtl/rs_issue_scheduler.sv
// Round-robin issue arbiter: RS ready entries -> one-deep issue register -> ALU.
// Optional RS_SCHED_STATS_EN adds stat_issued / stat_stalled counters.
module rs_issue_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4,
  parameter int ROB_W   = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic rs_clear,
  rs_issue_scheduler_if.master bus
`ifdef RS_SCHED_STATS_EN
  ,output logic [31:0] stat_issued
  ,output logic [31:0] stat_stalled
`endif
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic             any_rdy;
  logic             slot_open;
  logic             grant;
  logic [5:0]       sel_op;
  logic [31:0]      sel_vj;
  logic [31:0]      sel_vk;
  logic [ROB_W-1:0] sel_rob;

  // Scan from rr_ptr upward; index arithmetic wraps naturally at RS_SIZE.
  always_comb begin
    sel_idx = '0;
    any_rdy = 1'b0;
    for (int k = 0; k < RS_SIZE; k++) begin
      if (!any_rdy && bus.ent_ready[rr_ptr + IDX_W'(k)]) begin
        any_rdy = 1'b1;
        sel_idx = rr_ptr + IDX_W'(k);
      end
    end
  end

  always_comb begin
    sel_op  = bus.ent_op [sel_idx*6     +: 6];
    sel_vj  = bus.ent_vj [sel_idx*32    +: 32];
    sel_vk  = bus.ent_vk [sel_idx*32    +: 32];
    sel_rob = bus.ent_rob[sel_idx*ROB_W +: ROB_W];
  end

  assign slot_open      = (state_q == EMPTY) || bus.alu_ready;
  assign grant          = !rst_in && rdy_in && !rs_clear && slot_open && any_rdy;
  assign bus.free_valid = grant;
  assign bus.free_idx   = grant ? sel_idx : '0;
  assign bus.issue_valid = (state_q == FULL);

  // Flush wins over both ALU drain and a new grant.
  always_comb begin
    state_d = state_q;
    if (rdy_in) begin
      if (rs_clear)                               state_d = EMPTY;
      else if (grant)                             state_d = FULL;
      else if (state_q == FULL && bus.alu_ready)  state_d = EMPTY;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= EMPTY;
      rr_ptr        <= '0;
      bus.issue_op  <= '0;
      bus.issue_vj  <= '0;
      bus.issue_vk  <= '0;
      bus.issue_rob <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_ptr        <= sel_idx + IDX_W'(1);
        bus.issue_op  <= sel_op;
        bus.issue_vj  <= sel_vj;
        bus.issue_vk  <= sel_vk;
        bus.issue_rob <= sel_rob;
      end
    end
  end

`ifdef RS_SCHED_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_issued  <= '0;
      stat_stalled <= '0;
    end else if (rdy_in) begin
      if (grant)                                  stat_issued  <= stat_issued + 32'd1;
      if (state_q == FULL && !bus.alu_ready)      stat_stalled <= stat_stalled + 32'd1;
    end
  end
`endif
endmodule
